pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the 64-bit ripple adder: WIDTH-bit add/subtract with the carry chain split into STAGES registered chunks.
- Valid/ready streaming handshake with full backpressure; one operation accepted per cycle at full throughput.
- Produces sum, carry-out, signed overflow and zero flags.
- Sits between the ALU operand mux and the result writeback for multi-cycle arithmetic paths.

---
 rtl/pipelined_addsub_if.sv | 29 ++
 rtl/pipelined_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_addsub.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Streaming handshake bundle for the pipelined add/subtract unit.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  // Producer/consumer side of the unit
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  // The arithmetic unit itself
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// chunks. Operands skew forward, finished sum chunks de-skew forward, and the
// last stage is the output register. The whole pipe stalls as one unit.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned LAST  = STAGES - 1;

  logic                          advance;
  logic [WIDTH-1:0]              b_eff;
  logic                          c0;

  // Per-stage inputs (element 0 is the external operand)
  logic [STAGES-1:0][WIDTH-1:0]  a_src;
  logic [STAGES-1:0][WIDTH-1:0]  b_src;
  logic [STAGES-1:0][WIDTH-1:0]  s_src;
  logic [STAGES-1:0]             c_src;
  logic [STAGES-1:0]             v_src;

  // Per-stage results before registering
  logic [STAGES-1:0][WIDTH-1:0]  s_nx;
  logic [STAGES-1:0]             c_nx;

  logic [WIDTH-1:0]              res;
  logic                          ovf_nx;
  logic                          zero_nx;

  logic                          out_valid_q;
  logic [WIDTH-1:0]              sum_q;
  logic                          cout_q;
  logic                          ovf_q;
  logic                          zero_q;

  // A stalled, full output register freezes every stage
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction is addition of the inverted operand with inverted carry-in
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.cin ^ bus.sub;

  if (STAGES > 1) begin : g_skew
    localparam int unsigned NS = STAGES - 1;

    logic [NS-1:0][WIDTH-1:0] a_q;
    logic [NS-1:0][WIDTH-1:0] b_q;
    logic [NS-1:0][WIDTH-1:0] s_q;
    logic [NS-1:0]            c_q;
    logic [NS-1:0]            v_q;

    // Inter-stage registers: operand skew, partial sums, carries, valids
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= '0;
        v_q <= '0;
      end else if (advance) begin
        a_q <= a_src[NS-1:0];
        b_q <= b_src[NS-1:0];
        s_q <= s_nx[NS-1:0];
        c_q <= c_nx[NS-1:0];
        v_q <= v_src[NS-1:0];
      end
    end

    assign a_src = {a_q, bus.a};
    assign b_src = {b_q, b_eff};
    assign s_src = {s_q, WIDTH'(0)};
    assign c_src = {c_q, c0};
    assign v_src = {v_q, bus.in_valid};
  end else begin : g_single
    assign a_src = bus.a;
    assign b_src = b_eff;
    assign s_src = '0;
    assign c_src = c0;
    assign v_src = bus.in_valid;
  end

  // Each stage adds its own chunk and patches it into the travelling sum
  always_comb begin
    logic [CHUNK:0] part;
    s_nx = s_src;
    c_nx = '0;
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
           + (CHUNK+1)'(c_src[k]);
      s_nx[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_nx[k] = part[CHUNK];
    end
  end

  // Flags of the completed result, registered with it
  assign res     = s_nx[LAST];
  assign ovf_nx  = (a_src[LAST][MSB] == b_src[LAST][MSB]) && (res[MSB] != a_src[LAST][MSB]);
  assign zero_nx = (res == '0);

  // Output register; data only updates on a valid result so it holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= v_src[LAST];
      if (v_src[LAST]) begin
        sum_q  <= res;
        cout_q <= c_nx[LAST];
        ovf_q  <= ovf_nx;
        zero_q <= zero_nx;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: a 4-stage and a 1-stage instance, expected results queued
// at acceptance and compared when each result is consumed.
module tb_pipelined_addsub;
  localparam int unsigned W = 64;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    bit          lat;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t        q4[$];
  exp_t        q1[$];
  bit          hold_v[2];
  logic [63:0] hold_s[2];
  logic [2:0]  hold_f[2];
  int          n_out[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_addsub_if #(.WIDTH(W)) bus4 ();
  pipelined_addsub_if #(.WIDTH(W)) bus1 ();

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic co, input logic of,
                              input logic z, input bit lat);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = of; e.zero = z; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // Whole-width reference for the random and stream traffic
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [64:0] r;
    logic [63:0] be;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + 65'(cin ^ sub);
    return mk(r[63:0], r[64], (a[63] == be[63]) && (r[63] != a[63]), r[63:0] == 64'd0, 1'b0);
  endfunction

  task automatic drive(input int i, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub);
    if (i == 0) begin
      bus4.in_valid = v; bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub;
    end else begin
      bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub;
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 after the op was accepted
  task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub, input exp_t e);
    int  w;
    bit  rdy;
    w = 0;
    drive(i, 1'b1, a, b, cin, sub);
    forever begin
      @(negedge clk);
      rdy = (i == 0) ? bus4.in_ready : bus1.in_ready;
      if (rdy) begin
        e.acc_cyc = cyc;
        if (i == 0) q4.push_back(e); else q1.push_back(e);
        break;
      end
      w++;
      if (w >= 64) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    drive(i, 1'b0, a, b, cin, sub);
  endtask

  task automatic wait_idle(input int i);
    int w;
    w = 0;
    while (((i == 0) ? q4.size() : q1.size()) != 0 && w < 200) begin
      @(negedge clk); w++;
    end
    if (((i == 0) ? q4.size() : q1.size()) != 0) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic mon(input int i);
    logic        ov, ordy, ir, co, of, z;
    logic [63:0] s;
    exp_t        e;
    int          st;
    bit          empty;
    if (i == 0) begin
      ov = bus4.out_valid; ordy = bus4.out_ready; ir = bus4.in_ready;
      s = bus4.sum; co = bus4.cout; of = bus4.overflow; z = bus4.zero;
      st = 4; empty = (q4.size() == 0);
    end else begin
      ov = bus1.out_valid; ordy = bus1.out_ready; ir = bus1.in_ready;
      s = bus1.sum; co = bus1.cout; of = bus1.overflow; z = bus1.zero;
      st = 1; empty = (q1.size() == 0);
    end
    if (ov && !ordy) check("stall_in_ready", 64'(ir), 64'd0);
    if (hold_v[i] && ov) begin
      check("frozen_sum", s, hold_s[i]);
      check("frozen_flags", 64'({co, of, z}), 64'(hold_f[i]));
    end
    hold_v[i] = ov && !ordy;
    hold_s[i] = s;
    hold_f[i] = {co, of, z};
    if (ov && ordy) begin
      if (empty) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = (i == 0) ? q4.pop_front() : q1.pop_front();
        n_out[i]++;
        check("sum", s, e.sum);
        check("cout", 64'(co), 64'(e.cout));
        check("overflow", 64'(of), 64'(e.ovf));
        check("zero", 64'(z), 64'(e.zero));
        if (e.lat) check("latency", 64'(cyc - e.acc_cyc), 64'(st));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          base;
    logic [63:0] ra, rb;
    logic        rc, rs;

    drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    bus4.out_ready = 1'b1;
    bus1.out_ready = 1'b1;

    // Reset values while rst_n is held low
    #1;
    check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst_sum", bus4.sum, 64'd0);
    check("rst_flags", 64'({bus4.cout, bus4.overflow, bus4.zero}), 64'd0);
    check("rst_in_ready", 64'(bus4.in_ready), 64'd1);
    check("rst_in_ready1", 64'(bus1.in_ready), 64'd1);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed ops on the 4-stage pipe, back to back
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, mk(64'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    send(0, 64'd5, 64'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
    send(0, 64'd7, 64'd5, 1'b1, 1'b1, mk(64'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
         mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1));
    send(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
         mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1));
    wait_idle(0);

    // Single-stage instance: one cycle from acceptance
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, mk(64'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    send(1, 64'd5, 64'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_idle(1);

    // Three ops in flight, then asynchronous reset mid-cycle
    send(0, 64'd11, 64'd1, 1'b0, 1'b0, mk(64'd12, 1'b0, 1'b0, 1'b0, 1'b0));
    send(0, 64'd22, 64'd2, 1'b0, 1'b0, mk(64'd24, 1'b0, 1'b0, 1'b0, 1'b0));
    send(0, 64'd33, 64'd3, 1'b0, 1'b0, mk(64'd36, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    hold_v[0] = 1'b0;
    hold_v[1] = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("midrst_sum", bus4.sum, 64'd0);
    check("midrst_flags", 64'({bus4.cout, bus4.overflow, bus4.zero}), 64'd0);
    check("midrst_in_ready", 64'(bus4.in_ready), 64'd1);
    q4.delete();
    #10 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_result", 64'(bus4.out_valid), 64'd0);
    @(posedge clk); #1;
    send(0, 64'd10, 64'd20, 1'b0, 1'b0, mk(64'd30, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_idle(0);

    // 8-op stream with a 3-cycle stall once results emerge
    base = n_out[0];
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, 64'(i), 64'(i * 3), 1'b0, 1'b0, model(64'(i), 64'(i * 3), 1'b0, 1'b0));
      end
      begin
        w = 0;
        while (!bus4.out_valid && w < 64) begin
          @(negedge clk); w++;
        end
        if (!bus4.out_valid) check("stream_start_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 bus4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus4.out_ready = 1'b1;
      end
    join
    wait_idle(0);
    check("stream_count", 64'(n_out[0] - base), 64'd8);

    // Random traffic with random backpressure on both instances
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
          if (i % 7 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
          if (i % 5 == 0) rb = 64'h8000_0000_0000_0000;
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send(0, ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send(1, ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        for (int i = 0; i < 120; i++) begin
          @(posedge clk); #1;
          bus4.out_ready = ($urandom_range(0, 3) != 0);
          bus1.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus4.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
      end
    join
    wait_idle(0);
    wait_idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
